// File: rtl/key_sched_seq.sv
// AES key-expansion step sequencer: walks word indices Nk..last, tagging each step with its op and round constant.
// Optional abort input is compiled in when KSCHED_ABORT_EN is defined.
module key_sched_seq #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             step_ready,
`ifdef KSCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             key_load,
    output logic             step_valid,
    output logic [IDX_W-1:0] word_idx,
    output logic [1:0]       op,
    output logic [31:0]      rcon_word,
    output logic             done,
    output logic             err
);

    // Handshake: a step transfers on any rising edge where step_valid && step_ready;
    // while step_ready is low, word_idx/op/rcon_word are held unchanged.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_ROT  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] KL_RSVD = 2'd3;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_key_len;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_k;
    logic [3:0]       r_rcon;
    logic             r_err;

    logic [IDX_W-1:0] w_nk;
    logic [IDX_W-1:0] w_last;
    logic [2:0]       w_k_max;
    logic             w_abort;
    logic             w_start_ok;
    logic             w_accept;
    logic [1:0]       w_op;
    logic [31:0]      w_rcon;

`ifdef KSCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [31:0] rcon_lut(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd1:    v = 32'h0100_0000;
            4'd2:    v = 32'h0200_0000;
            4'd3:    v = 32'h0400_0000;
            4'd4:    v = 32'h0800_0000;
            4'd5:    v = 32'h1000_0000;
            4'd6:    v = 32'h2000_0000;
            4'd7:    v = 32'h4000_0000;
            4'd8:    v = 32'h8000_0000;
            4'd9:    v = 32'h1b00_0000;
            4'd10:   v = 32'h3600_0000;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    // Per-key-size geometry, derived from the key length latched at acceptance.
    always_comb begin
        w_nk    = IDX_W'(4);
        w_last  = IDX_W'(43);
        w_k_max = 3'd3;
        case (r_key_len)
            2'd1: begin
                w_nk    = IDX_W'(6);
                w_last  = IDX_W'(51);
                w_k_max = 3'd5;
            end
            2'd2: begin
                w_nk    = IDX_W'(8);
                w_last  = IDX_W'(59);
                w_k_max = 3'd7;
            end
            default: begin
                w_nk    = IDX_W'(4);
                w_last  = IDX_W'(43);
                w_k_max = 3'd3;
            end
        endcase
    end

    assign w_start_ok = (r_state == IDLE) && start && (key_len != KL_RSVD);
    assign w_accept   = (r_state == STEP) && step_ready && !w_abort;

    // The phase counter k replaces i mod Nk, so no divider is needed.
    always_comb begin
        w_op = OP_XOR;
        if (r_k == 3'd0) begin
            w_op = OP_ROT;
        end else if ((r_key_len == 2'd2) && (r_k == 3'd4)) begin
            w_op = OP_SUB;
        end
    end

    assign w_rcon = rcon_lut(r_rcon);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = w_abort ? IDLE : STEP;
            end
            STEP: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (w_accept && (r_idx == w_last)) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        key_load   = 1'b0;
        step_valid = 1'b0;
        done       = 1'b0;
        err        = r_err;
        word_idx   = '0;
        op         = OP_XOR;
        rcon_word  = 32'h0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                busy     = 1'b1;
                key_load = 1'b1;
            end
            STEP: begin
                busy       = 1'b1;
                step_valid = 1'b1;
                word_idx   = r_idx;
                op         = w_op;
                rcon_word  = (w_op == OP_ROT) ? w_rcon : 32'h0;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_len <= 2'd0;
            r_err     <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && (key_len == KL_RSVD);
            if (w_start_ok) begin
                r_key_len <= key_len;
            end
        end
    end

    // rcon saturates at 10: AES-128 wraps k once more on its final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_k    <= 3'd0;
            r_rcon <= 4'd0;
        end else if (r_state == LOAD) begin
            r_idx  <= w_nk;
            r_k    <= 3'd0;
            r_rcon <= 4'd1;
        end else if (w_accept) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_k == w_k_max) begin
                r_k <= 3'd0;
                if (r_rcon != 4'd10) begin
                    r_rcon <= r_rcon + 4'd1;
                end
            end else begin
                r_k <= r_k + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_sched_seq.sv
// Directed bench for key_sched_seq: full AES-128/192/256 schedules, backpressure, reserved key size, reset mid-run.
// Abort scenario is included when KSCHED_ABORT_EN is defined.
module tb_key_sched_seq;

    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       key_len = 2'd0;
    logic             step_ready = 1'b1;
`ifdef KSCHED_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy;
    logic             key_load;
    logic             step_valid;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       op;
    logic [31:0]      rcon_word;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    key_sched_seq #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .step_ready (step_ready),
`ifdef KSCHED_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .key_load   (key_load),
        .step_valid (step_valid),
        .word_idx   (word_idx),
        .op         (op),
        .rcon_word  (rcon_word),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIPS-197 round constants, first byte only.
    function automatic logic [31:0] exp_rcon_of(input int r);
        logic [31:0] v;
        case (r)
            1:       v = 32'h0100_0000;
            2:       v = 32'h0200_0000;
            3:       v = 32'h0400_0000;
            4:       v = 32'h0800_0000;
            5:       v = 32'h1000_0000;
            6:       v = 32'h2000_0000;
            7:       v = 32'h4000_0000;
            8:       v = 32'h8000_0000;
            9:       v = 32'h1b00_0000;
            10:      v = 32'h3600_0000;
            default: v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] exp_op(input int i, input int nk);
        if (i % nk == 0) return 2'b01;
        if (nk == 8 && i % 8 == 4) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rcon(input int i, input int nk);
        if (i % nk == 0) return exp_rcon_of(i / nk);
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_step(input int i, input int nk);
        check($sformatf("valid@%0d", i), 32'(step_valid), 32'd1);
        check($sformatf("idx@%0d", i), 32'(word_idx), 32'(i));
        check($sformatf("op@%0d", i), 32'(op), 32'(exp_op(i, nk)));
        check($sformatf("rcon@%0d", i), rcon_word, exp_rcon(i, nk));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_key_load"}, 32'(key_load), 32'd0);
        check({tag, "_step_valid"}, 32'(step_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_word_idx"}, 32'(word_idx), 32'd0);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_rcon"}, rcon_word, 32'd0);
    endtask

    // Starts a schedule and, from the accept edge, checks key_load, then each step up to stop_idx.
    task automatic begin_sched(input logic [1:0] kl, input int nk, input int stop_idx, input int stall_idx);
        start = 1'b1;
        key_len = kl;
        step_ready = 1'b1;
        tick();
        start = 1'b0;
        key_len = 2'd3;
        check("key_load", 32'(key_load), 32'd1);
        check("busy_load", 32'(busy), 32'd1);
        check("valid_load", 32'(step_valid), 32'd0);
        tick();
        for (int i = nk; i < stop_idx; i++) begin
            if (i == stall_idx) begin
                step_ready = 1'b0;
                start = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    check_step(i, nk);
                    tick();
                end
                step_ready = 1'b1;
                start = 1'b0;
            end
            check_step(i, nk);
            tick();
        end
    endtask

    task automatic run_sched(input logic [1:0] kl, input int nk, input int last, input int stall_idx);
        begin_sched(kl, nk, last + 1, stall_idx);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd1);
        check("valid_fin", 32'(step_valid), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        run_sched(2'd0, 4, 43, 8);
        run_sched(2'd2, 8, 59, -1);
        run_sched(2'd1, 6, 51, -1);

        // Reserved key size: err pulse only.
        start = 1'b1;
        key_len = 2'd3;
        tick();
        start = 1'b0;
        key_len = 2'd0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_keyload", 32'(key_load), 32'd0);
        tick();
        check("err_clear", 32'(err), 32'd0);
        check("err_busy2", 32'(busy), 32'd0);

        // Reset asserted mid-schedule, between edges.
        begin_sched(2'd0, 4, 20, -1);
        check_step(20, 4);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("midrst_nodone%0d", c), 32'(done), 32'd0);
            tick();
        end
        run_sched(2'd1, 6, 51, -1);

`ifdef KSCHED_ABORT_EN
        begin_sched(2'd0, 4, 10, -1);
        check_step(10, 4);
        abort = 1'b1;
        step_ready = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        tick();
        check("abort_nodone", 32'(done), 32'd0);
        run_sched(2'd0, 4, 43, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
